// File: rtl/halt_dump_pkg.sv
// Shared types and default widths for the end-of-simulation halt dump unit.
package halt_dump_pkg;

  localparam int NUM_REGS_DEF = 32;
  localparam int XLEN_DEF     = 32;
  localparam int CNT_W_DEF    = 32;

  localparam logic KIND_CYCLE = 1'b0;
  localparam logic KIND_REG   = 1'b1;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    CYC  = 2'd1,
    REGS = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/halt_dump_unit_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/halt_dump_unit.sv
// Counts cycles until halt, then streams the cycle count and every register over valid/ready.
// Optional DUMP_SKIP_ZERO_EN: registers reading zero are skipped without producing a record.
module halt_dump_unit
  import halt_dump_pkg::*;
#(
  parameter int  NUM_REGS = NUM_REGS_DEF,
  parameter int  XLEN     = XLEN_DEF,
  parameter int  CNT_W    = CNT_W_DEF,
  localparam int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             is_halted,
  output logic [IDX_W-1:0] rf_rd_addr,
  input  logic [XLEN-1:0]  rf_rd_data,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic             dump_kind,
  output logic [IDX_W-1:0] dump_index,
  output logic [XLEN-1:0]  dump_data,
  output logic             dump_done
);

  // One extra bit so idx can reach NUM_REGS as the end marker.
  localparam int IW = IDX_W + 1;

`ifdef DUMP_SKIP_ZERO_EN
  localparam bit SKIP_ZERO = 1'b1;
`else
  localparam bit SKIP_ZERO = 1'b0;
`endif

  state_e           state;
  logic [IW-1:0]    idx;
  logic [CNT_W-1:0] cycle_cnt;
  logic             slot_free;
  logic             at_end;
  logic             skip_reg;

  sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .en    ((state == RUN) && !is_halted),
    .cnt   (cycle_cnt)
  );

  assign rf_rd_addr = idx[IDX_W-1:0];
  assign slot_free  = !dump_valid || dump_ready;
  assign at_end     = (idx == IW'(NUM_REGS));
  assign skip_reg   = SKIP_ZERO && (rf_rd_data == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      idx        <= '0;
      dump_valid <= 1'b0;
      dump_kind  <= KIND_CYCLE;
      dump_index <= '0;
      dump_data  <= '0;
      dump_done  <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (is_halted) begin
            dump_valid <= 1'b1;
            dump_kind  <= KIND_CYCLE;
            dump_index <= '0;
            dump_data  <= XLEN'(cycle_cnt);
            state      <= CYC;
          end
        end
        // CYC always has a full slot, so slot_free here means the cycle record transferred.
        CYC, REGS: begin
          if (slot_free) begin
            if (at_end) begin
              dump_valid <= 1'b0;
              dump_done  <= 1'b1;
              state      <= DONE;
            end else begin
              if (skip_reg) begin
                dump_valid <= 1'b0;
              end else begin
                dump_valid <= 1'b1;
                dump_kind  <= KIND_REG;
                dump_index <= idx[IDX_W-1:0];
                dump_data  <= rf_rd_data;
              end
              idx   <= idx + IW'(1);
              state <= REGS;
            end
          end
        end
        DONE: begin
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_halt_dump_unit.sv
// Directed-sequence bench with randomized register contents, halt delays and ready patterns.
module tb_halt_dump_unit;

  localparam int NR = 32;
`ifdef DUMP_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, is_halted, dump_ready;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic        dump_valid, dump_kind, dump_done;
  logic [4:0]  dump_index;
  logic [31:0] dump_data;
  logic [31:0] rf [NR];

  assign rf_rd_data = rf[rf_rd_addr];

  halt_dump_unit dut (
    .clk        (clk),
    .reset      (reset),
    .is_halted  (is_halted),
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_data (rf_rd_data),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_kind  (dump_kind),
    .dump_index (dump_index),
    .dump_data  (dump_data),
    .dump_done  (dump_done)
  );

  // Small instance with a 4-bit counter for the saturation case.
  logic        rst_s, halt_s, ready_s;
  logic [1:0]  addr_s, index_s;
  logic [31:0] rdata_s, data_s;
  logic        valid_s, kind_s, done_s;

  assign rdata_s = 32'h100 + 32'(addr_s);

  halt_dump_unit #(.NUM_REGS(4), .XLEN(32), .CNT_W(4)) dut_sat (
    .clk        (clk),
    .reset      (rst_s),
    .is_halted  (halt_s),
    .rf_rd_addr (addr_s),
    .rf_rd_data (rdata_s),
    .dump_valid (valid_s),
    .dump_ready (ready_s),
    .dump_kind  (kind_s),
    .dump_index (index_s),
    .dump_data  (data_s),
    .dump_done  (done_s)
  );

  typedef struct {
    logic        k;
    int          i;
    logic [31:0] d;
  } rec_t;

  rec_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: cycle record first, then every register in index order (zeros dropped when skipping).
  task automatic build_expected(input int cyc);
    exp_q.delete();
    exp_q.push_back('{1'b0, 0, 32'(cyc)});
    for (int r = 0; r < NR; r++)
      if (!SKIP || rf[r] != 32'h0) exp_q.push_back('{1'b1, r, rf[r]});
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, dump_valid, 0);
    chk({tag, "_kind"},  dump_kind,  0);
    chk({tag, "_index"}, dump_index, 0);
    chk({tag, "_data"},  dump_data,  0);
    chk({tag, "_done"},  dump_done,  0);
    chk({tag, "_addr"},  rf_rd_addr, 0);
  endtask

  task automatic start_run(input int delay);
    @(negedge clk);
    reset = 1'b0; is_halted = 1'b0; dump_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (delay) @(negedge clk);
    is_halted = 1'b1;
  endtask

  // mode: 0 = ready always high, 1 = toggling, 2 = random.
  task automatic run_dump(input int mode, input bit pulse, input int abort_idx,
                          output int nrec, output int last_c, output int done_c,
                          output int bubbles, output bit aborted);
    bit held = 1'b0;
    bit got_done = 1'b0;
    int pos = 0;
    last_c = -1; done_c = -1; bubbles = 0; aborted = 1'b0;
    for (int c = 0; c < 400 && !got_done && !aborted; c++) begin
      @(negedge clk);
      if (pulse && c == 0) is_halted = 1'b0;
      if (dump_done) begin
        got_done = 1'b1;
        done_c = c;
        chk("valid_at_done", dump_valid, 0);
      end else if (abort_idx >= 0 && dump_valid && dump_kind && dump_index == 5'(abort_idx)) begin
        #1 reset = 1'b0;
        #1 check_all_zero("abort");
        is_halted = 1'b0;
        aborted = 1'b1;
      end else begin
        if (held && pos < exp_q.size()) begin
          chk("held_valid", dump_valid, 1);
          chk("held_kind",  dump_kind,  exp_q[pos].k);
          chk("held_index", dump_index, 64'(exp_q[pos].i));
          chk("held_data",  dump_data,  exp_q[pos].d);
        end
        case (mode)
          0:       dump_ready = 1'b1;
          1:       dump_ready = c[0];
          default: dump_ready = 1'($urandom);
        endcase
        if (dump_valid) begin
          if (pos >= exp_q.size()) begin
            chk("extra_record", 1, 0);
          end else if (dump_ready) begin
            chk("rec_kind",  dump_kind,  exp_q[pos].k);
            chk("rec_index", dump_index, 64'(exp_q[pos].i));
            chk("rec_data",  dump_data,  exp_q[pos].d);
            pos++;
            last_c = c;
          end
        end else begin
          bubbles++;
        end
        held = dump_valid && !dump_ready;
      end
    end
    if (!aborted) chk("done_seen", got_done, 1);
    nrec = pos;
  endtask

  initial begin
    int  nrec, last_c, done_c, bubbles, p, d;
    bit  aborted;

    reset = 1'b1; is_halted = 1'b0; dump_ready = 1'b0;
    rst_s = 1'b0; halt_s = 1'b0; ready_s = 1'b0;
    foreach (rf[i]) rf[i] = $urandom;
    #2 reset = 1'b0;
    #1 check_all_zero("reset");

    // Halt after 10 edges, continuous ready: back-to-back records, done one edge after the last.
    foreach (rf[i]) rf[i] = $urandom | 32'h1;
    start_run(10);
    build_expected(10);
    run_dump(0, 1'b0, -1, nrec, last_c, done_c, bubbles, aborted);
    chk("A_nrec", nrec, 33);
    chk("A_done_lag", done_c - last_c, 1);
    chk("A_bubbles", bubbles, 0);

    // Toggling ready with some zero registers and a random halt delay.
    foreach (rf[i]) rf[i] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
    d = $urandom_range(1, 25);
    start_run(d);
    build_expected(d);
    run_dump(1, 1'b0, -1, nrec, last_c, done_c, bubbles, aborted);
    chk("B_nrec", nrec, exp_q.size());

    // Reset mid-dump at index 17, then restart with halt after 3 edges.
    foreach (rf[i]) rf[i] = $urandom | 32'h1;
    start_run(4);
    build_expected(4);
    run_dump(2, 1'b0, 17, nrec, last_c, done_c, bubbles, aborted);
    chk("C_aborted", aborted, 1);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    is_halted = 1'b1;
    build_expected(3);
    run_dump(0, 1'b0, -1, nrec, last_c, done_c, bubbles, aborted);
    chk("C_nrec", nrec, 33);

    // Halted at reset release, one-edge pulse: cycle record is 0 and the dump still completes.
    foreach (rf[i]) rf[i] = $urandom;
    start_run(0);
    build_expected(0);
    run_dump(2, 1'b1, -1, nrec, last_c, done_c, bubbles, aborted);
    chk("D_nrec", nrec, exp_q.size());
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      is_halted  = 1'($urandom);
      dump_ready = 1'($urandom);
      chk("sticky_done",  dump_done,  1);
      chk("sticky_valid", dump_valid, 0);
    end

    // Sparse register file: with skipping only the two non-zero registers follow the cycle record.
    foreach (rf[i]) rf[i] = 32'h0;
    rf[5]  = 32'hDEADBEEF;
    rf[31] = 32'h1;
    start_run(7);
    build_expected(7);
    run_dump(1, 1'b0, -1, nrec, last_c, done_c, bubbles, aborted);
    chk("E_nrec", nrec, SKIP ? 3 : 33);

    // 4-bit counter, halt after 20 edges: cycle record saturates at 15.
    @(negedge clk);
    rst_s = 1'b1;
    repeat (20) @(negedge clk);
    halt_s = 1'b1; ready_s = 1'b1;
    p = 0;
    for (int c = 0; c < 30 && !done_s; c++) begin
      @(negedge clk);
      if (valid_s && !done_s) begin
        chk("S_kind",  kind_s,  (p == 0) ? 0 : 1);
        chk("S_index", index_s, (p == 0) ? 0 : 64'(p - 1));
        chk("S_data",  data_s,  (p == 0) ? 64'd15 : 64'(32'h100 + 32'(p - 1)));
        p++;
      end
    end
    chk("S_done", done_s, 1);
    chk("S_nrec", p, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
